// File: rtl/dff_pipe_pkg.sv
// Shared defaults and width helpers for the dff_pipe register pipeline.
package dff_pipe_pkg;

    localparam int DEFAULT_WIDTH   = 4;
    localparam int DEFAULT_DEPTH   = 3;
    localparam int DEFAULT_RST_VAL = 0;

    // Width of the occupancy counter: must represent 0..depth inclusive.
    function automatic int cntWidth(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int tapWidth(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/dff_pipe_stage.sv
// One pipeline stage: a WIDTH-bit data register plus its valid bit.
module dff_pipe_stage #(
    parameter int               WIDTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_flush,
    input  logic [WIDTH-1:0] i_d,
    input  logic             i_vld,
    output logic [WIDTH-1:0] o_q,
    output logic             o_vld
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             vld_q, vld_d;

    // Data follows the enable even while flushing; only the valid bit is cleared.
    always_comb begin
        data_d = data_q;
        vld_d  = vld_q;
        if (i_en) begin
            data_d = i_d;
            vld_d  = i_vld;
        end
        if (i_flush) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            data_q <= RST_VAL;
            vld_q  <= 1'b0;
        end else begin
            data_q <= data_d;
            vld_q  <= vld_d;
        end
    end

    assign o_q   = data_q;
    assign o_vld = vld_q;

endmodule

// File: rtl/dff_pipe.sv
// DEPTH-stage data/valid shift pipeline with registered occupancy count.
// Optional stage tap outputs are enabled by defining DFF_PIPE_TAP_EN.
module dff_pipe
    import dff_pipe_pkg::*;
#(
    parameter int               WIDTH   = DEFAULT_WIDTH,
    parameter int               DEPTH   = DEFAULT_DEPTH,
    parameter logic [WIDTH-1:0] RST_VAL = WIDTH'(DEFAULT_RST_VAL)
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_en,
    input  logic                         i_flush,
    input  logic [WIDTH-1:0]             i_d,
    input  logic                         i_vld,
    output logic [WIDTH-1:0]             o_q,
    output logic                         o_vld,
    output logic [cntWidth(DEPTH)-1:0]   o_cnt
`ifdef DFF_PIPE_TAP_EN
    ,
    input  logic [tapWidth(DEPTH)-1:0]   i_tap_sel,
    output logic [WIDTH-1:0]             o_tap,
    output logic                         o_tap_vld
`endif
);

    localparam int CW = cntWidth(DEPTH);

    logic [WIDTH-1:0] stageData [DEPTH];
    logic             stageVld  [DEPTH];

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        if (k == 0) begin : g_first
            dff_pipe_stage #(.WIDTH(WIDTH), .RST_VAL(RST_VAL)) u_stage (
                .i_clk   (i_clk),
                .i_rst   (i_rst),
                .i_en    (i_en),
                .i_flush (i_flush),
                .i_d     (i_d),
                .i_vld   (i_vld),
                .o_q     (stageData[k]),
                .o_vld   (stageVld[k])
            );
        end else begin : g_next
            dff_pipe_stage #(.WIDTH(WIDTH), .RST_VAL(RST_VAL)) u_stage (
                .i_clk   (i_clk),
                .i_rst   (i_rst),
                .i_en    (i_en),
                .i_flush (i_flush),
                .i_d     (stageData[k-1]),
                .i_vld   (stageVld[k-1]),
                .o_q     (stageData[k]),
                .o_vld   (stageVld[k])
            );
        end
    end

    logic [CW-1:0] cnt_q, cnt_d;

    // Incremental popcount: one sample may enter and one may leave per edge.
    always_comb begin
        cnt_d = cnt_q;
        if (i_en) begin
            if (i_vld && !stageVld[DEPTH-1]) begin
                cnt_d = cnt_q + CW'(1);
            end else if (!i_vld && stageVld[DEPTH-1]) begin
                cnt_d = cnt_q - CW'(1);
            end
        end
        if (i_flush) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_q   = stageData[DEPTH-1];
    assign o_vld = stageVld[DEPTH-1];
    assign o_cnt = cnt_q;

`ifdef DFF_PIPE_TAP_EN
    localparam int TW = tapWidth(DEPTH);

    // Out-of-range selects fall through to the reset value with no valid.
    always_comb begin
        o_tap     = RST_VAL;
        o_tap_vld = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if (i_tap_sel == TW'(k)) begin
                o_tap     = stageData[k];
                o_tap_vld = stageVld[k];
            end
        end
    end
`endif

endmodule
